// File: rtl/qmca_pkg.sv
// Shared definitions for the qmca channel selector: mode encodings and lock FSM states.
package qmca_pkg;

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_AUTO  = 2'b01;
    localparam logic [1:0] MODE_LOCK  = 2'b10;

    typedef logic [0:0] lock_state_t;
    localparam lock_state_t ST_FREE   = 1'b0;
    localparam lock_state_t ST_LOCKED = 1'b1;

endpackage

// File: rtl/qmca_argmax.sv
// Combinational argmax over NCH unsigned samples; the lowest index wins ties.
module qmca_argmax #(
    parameter  int NCH       = 4,
    parameter  int ADC_WIDTH = 14,
    localparam int CH_W      = $clog2(NCH)
) (
    input  logic [NCH*ADC_WIDTH-1:0] i_adc,
    output logic [CH_W-1:0]          o_idx,
    output logic [ADC_WIDTH-1:0]     o_val
);

    always_comb begin
        o_idx = '0;
        o_val = i_adc[0 +: ADC_WIDTH];
        // Strict '>' keeps the earlier (lower) index on equal values.
        for (int unsigned k = 1; k < NCH; k++) begin
            if (i_adc[k*ADC_WIDTH +: ADC_WIDTH] > o_val) begin
                o_idx = CH_W'(k);
                o_val = i_adc[k*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

endmodule

// File: rtl/qmca_channel_select.sv
// Two-stage channel selector: registered input stage, then mode mux (fixed/auto/auto-lock)
// with a lock FSM that pins the selection to a channel while a pulse is in progress.
module qmca_channel_select
    import qmca_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int ADC_WIDTH = 14,
    parameter  int HOLD_W    = 8,
    localparam int CH_W      = $clog2(NCH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               conf_mode,
    input  logic [CH_W-1:0]          conf_channel,
    input  logic [ADC_WIDTH-1:0]     conf_threshold,
    input  logic [HOLD_W-1:0]        conf_hold,
    input  logic                     adc_valid,
    input  logic [NCH*ADC_WIDTH-1:0] adc_in,
    output logic                     sel_valid,
    output logic [CH_W-1:0]          sel_channel,
    output logic [ADC_WIDTH-1:0]     sel_adc_in,
    output logic                     sel_locked,
    output logic                     conf_error
);

    localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

    logic [NCH*ADC_WIDTH-1:0] r_adc;
    logic                     r_valid;
    logic                     r_sel_valid;
    logic [CH_W-1:0]          r_sel_channel;
    logic [ADC_WIDTH-1:0]     r_sel_adc;
    logic                     r_sel_locked;
    logic                     r_conf_error;
    lock_state_t              r_state;
    logic [CH_W-1:0]          r_lock_ch;
    logic [HOLD_W-1:0]        r_cnt;

    logic [ADC_WIDTH-1:0]     w_samp [NCH];
    logic [CH_W-1:0]          w_max_idx;
    logic [ADC_WIDTH-1:0]     w_max_val;
    logic                     w_cfg_err;
    logic [CH_W-1:0]          w_ch;
    logic                     w_locked;
    lock_state_t              w_state_nxt;
    logic [CH_W-1:0]          w_lock_ch_nxt;
    logic [HOLD_W-1:0]        w_cnt_nxt;

    qmca_argmax #(
        .NCH       (NCH),
        .ADC_WIDTH (ADC_WIDTH)
    ) u_argmax (
        .i_adc (r_adc),
        .o_idx (w_max_idx),
        .o_val (w_max_val)
    );

    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            w_samp[k] = r_adc[k*ADC_WIDTH +: ADC_WIDTH];
        end
    end

    assign w_cfg_err = (conf_mode == MODE_FIXED) && ({1'b0, conf_channel} >= NCH_L);

    // Any mode other than auto-lock defaults the FSM back to FREE with a cleared counter.
    always_comb begin
        w_ch          = w_max_idx;
        w_locked      = 1'b0;
        w_state_nxt   = ST_FREE;
        w_cnt_nxt     = '0;
        w_lock_ch_nxt = r_lock_ch;
        case (conf_mode)
            MODE_FIXED: w_ch = w_cfg_err ? '0 : conf_channel;
            MODE_LOCK: begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                if (r_valid) begin
                    if (r_state == ST_LOCKED && r_cnt != '0) begin
                        w_ch      = r_lock_ch;
                        w_locked  = 1'b1;
                        w_cnt_nxt = r_cnt - HOLD_W'(1);
                    end else if (r_state == ST_LOCKED && w_samp[r_lock_ch] >= conf_threshold) begin
                        w_ch     = r_lock_ch;
                        w_locked = 1'b1;
                    end else if (w_max_val >= conf_threshold) begin
                        // Release (if locked) and re-evaluate the same sample as FREE.
                        w_locked      = 1'b1;
                        w_state_nxt   = ST_LOCKED;
                        w_lock_ch_nxt = w_max_idx;
                        w_cnt_nxt     = conf_hold;
                    end else begin
                        w_state_nxt = ST_FREE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adc         <= '0;
            r_valid       <= 1'b0;
            r_sel_valid   <= 1'b0;
            r_sel_channel <= '0;
            r_sel_adc     <= '0;
            r_sel_locked  <= 1'b0;
            r_conf_error  <= 1'b0;
            r_state       <= ST_FREE;
            r_lock_ch     <= '0;
            r_cnt         <= '0;
        end else begin
            r_adc        <= adc_in;
            r_valid      <= adc_valid;
            r_sel_valid  <= r_valid;
            r_conf_error <= w_cfg_err;
            r_state      <= w_state_nxt;
            r_lock_ch    <= w_lock_ch_nxt;
            r_cnt        <= w_cnt_nxt;
            if (r_valid) begin
                r_sel_channel <= w_ch;
                r_sel_adc     <= w_samp[w_ch];
                r_sel_locked  <= w_locked;
            end
        end
    end

    assign sel_valid   = r_sel_valid;
    assign sel_channel = r_sel_channel;
    assign sel_adc_in  = r_sel_adc;
    assign sel_locked  = r_sel_locked;
    assign conf_error  = r_conf_error;

endmodule

// File: tb/tb_qmca_channel_select.sv
// Scoreboard bench for qmca_channel_select (4-channel main instance plus a 3-channel instance).
module tb_qmca_channel_select;

    localparam logic [1:0] M_FIXED = 2'b00;
    localparam logic [1:0] M_AUTO  = 2'b01;
    localparam logic [1:0] M_LOCK  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  conf_mode;
    logic [1:0]  conf_channel;
    logic [13:0] conf_threshold;
    logic [7:0]  conf_hold;
    logic        adc_valid;
    logic [55:0] adc_in;
    logic        sel_valid;
    logic [1:0]  sel_channel;
    logic [13:0] sel_adc_in;
    logic        sel_locked;
    logic        conf_error;

    logic [1:0]  conf_mode3;
    logic [1:0]  conf_channel3;
    logic        adc_valid3;
    logic [41:0] adc_in3;
    logic        sel_valid3;
    logic [1:0]  sel_channel3;
    logic [13:0] sel_adc_in3;
    logic        sel_locked3;
    logic        conf_error3;

    typedef struct {
        int ch;
        int val;
        int lk;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_locked;
    int   m_ch;
    int   m_cnt;

    qmca_channel_select #(.NCH(4), .ADC_WIDTH(14), .HOLD_W(8)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .conf_mode      (conf_mode),
        .conf_channel   (conf_channel),
        .conf_threshold (conf_threshold),
        .conf_hold      (conf_hold),
        .adc_valid      (adc_valid),
        .adc_in         (adc_in),
        .sel_valid      (sel_valid),
        .sel_channel    (sel_channel),
        .sel_adc_in     (sel_adc_in),
        .sel_locked     (sel_locked),
        .conf_error     (conf_error)
    );

    qmca_channel_select #(.NCH(3), .ADC_WIDTH(14), .HOLD_W(8)) u_dut3 (
        .clk            (clk),
        .rst            (rst),
        .conf_mode      (conf_mode3),
        .conf_channel   (conf_channel3),
        .conf_threshold (conf_threshold),
        .conf_hold      (conf_hold),
        .adc_valid      (adc_valid3),
        .adc_in         (adc_in3),
        .sel_valid      (sel_valid3),
        .sel_channel    (sel_channel3),
        .sel_adc_in     (sel_adc_in3),
        .sel_locked     (sel_locked3),
        .conf_error     (conf_error3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [55:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {14'(a3), 14'(a2), 14'(a1), 14'(a0)};
    endfunction

    // Drive one valid sample for one clock and queue its expected selection.
    task automatic send(input logic [55:0] v, input int ch, input int val, input int lk);
        exp_t e;
        e.ch = ch; e.val = val; e.lk = lk; e.cyc = cyc;
        q.push_back(e);
        adc_in    = v;
        adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int samp(input logic [55:0] v, input int k);
        logic [13:0] s;
        s = v[k*14 +: 14];
        return int'(s);
    endfunction

    // Reference auto-lock behaviour for one valid sample.
    task automatic model_lock(input logic [55:0] v, output int ch, output int val, output int lk);
        int best;
        int thr;
        thr  = int'(conf_threshold);
        best = 0;
        for (int k = 1; k < 4; k++)
            if (samp(v, k) > samp(v, best)) best = k;
        if (m_locked != 0 && m_cnt != 0) begin
            ch = m_ch; lk = 1; m_cnt = m_cnt - 1;
        end else if (m_locked != 0 && samp(v, m_ch) >= thr) begin
            ch = m_ch; lk = 1;
        end else begin
            m_locked = 0;
            ch = best;
            lk = 0;
            if (samp(v, best) >= thr) begin
                m_locked = 1; m_ch = best; m_cnt = int'(conf_hold); lk = 1;
            end
        end
        val = samp(v, ch);
    endtask

    always @(negedge clk) begin
        if (!rst && sel_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(sel_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 32'(cyc - e.cyc), 32'd2);
                chk("channel", 32'(sel_channel), 32'(e.ch));
                chk("value",   32'(sel_adc_in),  32'(e.val));
                chk("locked",  32'(sel_locked),  32'(e.lk));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [55:0] v;
        int ch, val, lk;

        rst = 1'b1;
        conf_mode = M_AUTO; conf_channel = 2'd0; conf_threshold = 14'd1000; conf_hold = 8'd2;
        adc_valid = 1'b0; adc_in = '0;
        conf_mode3 = M_FIXED; conf_channel3 = 2'd0; adc_valid3 = 1'b0; adc_in3 = '0;
        #12;
        chk("reset_state", 32'({sel_valid, sel_channel, sel_adc_in, sel_locked, conf_error}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Auto mode, including ties and full-scale values
        send(pk(10, 20, 30, 40), 3, 40, 0);
        send(pk(500, 500, 100, 500), 0, 500, 0);
        send(pk(1, 2, 3, 16383), 3, 16383, 0);
        send(pk(7, 9, 9, 2), 1, 9, 0);
        idle(3);
        conf_mode = 2'b11;
        idle(2);
        send(pk(3, 8, 1, 2), 1, 8, 0);
        idle(3);

        // Asynchronous reset with samples in flight
        conf_mode = M_AUTO;
        send(pk(0, 0, 0, 900), 3, 900, 0);
        send(pk(0, 700, 0, 0), 1, 700, 0);
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("reset_async", 32'({sel_valid, sel_channel, sel_adc_in, sel_locked, conf_error}), 32'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        idle(4);

        // Fixed channel on the 4-channel build
        conf_mode = M_FIXED; conf_channel = 2'd2;
        idle(2);
        send(pk(10, 20, 30, 40), 2, 30, 0);
        idle(2);
        chk("conf_error4", 32'(conf_error), 32'd0);

        // Fixed out-of-range on the 3-channel build
        conf_channel3 = 2'd3;
        adc_in3 = {14'd30, 14'd20, 14'd10};
        adc_valid3 = 1'b1;
        @(posedge clk); #1; adc_valid3 = 1'b0;
        @(posedge clk); #1;
        chk("n3_valid", 32'(sel_valid3), 32'd1);
        chk("n3_channel", 32'(sel_channel3), 32'd0);
        chk("n3_value", 32'(sel_adc_in3), 32'd10);
        chk("n3_conf_error", 32'(conf_error3), 32'd1);
        conf_channel3 = 2'd1;
        adc_valid3 = 1'b1;
        @(posedge clk); #1; adc_valid3 = 1'b0;
        @(posedge clk); #1;
        chk("n3_channel_ok", 32'(sel_channel3), 32'd1);
        chk("n3_value_ok", 32'(sel_adc_in3), 32'd20);
        chk("n3_conf_error_clr", 32'(conf_error3), 32'd0);
        chk("n3_locked", 32'(sel_locked3), 32'd0);
        idle(2);

        // Lock and hold, back-to-back samples
        conf_mode = M_LOCK; conf_threshold = 14'd1000; conf_hold = 8'd2;
        idle(3);
        send(pk(0, 1200, 0, 0), 1, 1200, 1);
        send(pk(0, 0, 0, 5000), 1, 0, 1);
        send(pk(0, 0, 0, 5000), 1, 0, 1);
        send(pk(0, 0, 0, 5000), 3, 5000, 1);
        idle(3);
        conf_mode = M_AUTO; idle(2);
        conf_mode = M_LOCK; idle(2);

        // Lock with idle gaps: the hold counts valid samples only
        send(pk(0, 1200, 0, 0), 1, 1200, 1);
        idle(5);
        send(pk(0, 0, 0, 5000), 1, 0, 1);
        idle(3);
        send(pk(0, 0, 0, 5000), 1, 0, 1);
        idle(2);
        send(pk(0, 0, 0, 5000), 3, 5000, 1);
        idle(3);

        // Leaving auto-lock while LOCKED, then returning
        conf_mode = M_AUTO; idle(2);
        send(pk(0, 0, 800, 0), 2, 800, 0);
        idle(3);
        conf_mode = M_LOCK; idle(2);
        send(pk(0, 0, 700, 0), 2, 700, 0);
        idle(3);

        // Randomised auto-lock streams against the reference model
        for (int h = 0; h < 2; h++) begin
            conf_mode = M_AUTO; idle(2);
            conf_hold = 8'(h * 3);
            conf_mode = M_LOCK; idle(2);
            m_locked = 0; m_ch = 0; m_cnt = 0;
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle(1);
                end else begin
                    for (int k = 0; k < 4; k++)
                        v[k*14 +: 14] = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                                                    : 14'($urandom_range(0, 1200));
                    model_lock(v, ch, val, lk);
                    send(v, ch, val, lk);
                end
            end
            idle(3);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qmca_channel_select.md
Name: qmca_channel_select

Overview:
- Parametrised, pipelined channel selector for the qmca multichannel ADC front end.
- Takes NCH flattened ADC samples with a valid strobe and outputs one selected sample plus its channel index to the downstream histogrammer.
- Modes:
  - fixed channel;
  - auto (largest sample);
  - auto-lock: once a pulse crosses threshold, the selection is held on that channel for a configurable number of samples, so pile-up on a neighbour cannot steal the pulse.

Parameters:
- NCH, 4, number of ADC channels (2..16).
- ADC_WIDTH, 14, bits per sample.
- HOLD_W, 8, width of hold counter / conf_hold.
- CH_W, $clog2(NCH), channel index width (derived localparam, not overridable).

Ports:
- clk  in  1  sample clock.
- rst  in  1  asynchronous, active-high reset.
- conf_mode  in  2  00 fixed, 01 auto, 10 auto-lock, 11 treated as auto.
- conf_channel  in  CH_W  channel used in fixed mode.
- conf_threshold  in  ADC_WIDTH  lock threshold (unsigned).
- conf_hold  in  HOLD_W  minimum extra locked samples after lock.
- adc_valid  in  1  adc_in carries a sample this cycle.
- adc_in  in  NCH*ADC_WIDTH  channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
- sel_valid  out  1  sel_* valid this cycle.
- sel_channel  out  CH_W  selected channel index.
- sel_adc_in  out  ADC_WIDTH  selected sample.
- sel_locked  out  1  sample was selected under lock.
- conf_error  out  1  registered: fixed mode with conf_channel >= NCH.

Behaviour:
- Reset (async): all outputs 0, stage-1 regs 0, FSM FREE, hold counter 0.
- Stage 1, every clk: register adc_in and adc_valid unconditionally.
- Stage 2, every clk:
  - register sel_valid from the stage-1 valid;
  - on a stage-1-valid cycle, update sel_* and the FSM;
  - otherwise sel_channel / sel_adc_in / sel_locked hold their value.
- Latency: exactly 2 clk from adc_valid to sel_valid. Throughput: one sample per clk.
- Compares are unsigned, full ADC_WIDTH, no truncation.
- Argmax: on ties the lowest index wins.
- Config is sampled combinationally at stage 2, so a change affects the first sample reaching stage 2 after it.
- Fixed mode:
  - output channel conf_channel, sel_locked=0;
  - if conf_channel >= NCH: output channel 0, conf_error=1;
  - conf_error=0 in all other cases.
- Auto mode: output argmax, sel_locked=0.
- Auto-lock FSM, advanced only on valid samples:
  - FREE:
    - evaluate argmax m, value v;
    - if v >= conf_threshold: output m with sel_locked=1, latch lock_ch=m, cnt=conf_hold, go to LOCKED;
    - else output m with sel_locked=0.
  - LOCKED:
    - if cnt != 0: output lock_ch with sel_locked=1, decrement cnt;
    - else if adc[lock_ch] >= conf_threshold: output lock_ch with sel_locked=1, stay;
    - else release: go to FREE and evaluate the same sample as FREE in the same cycle (may re-lock immediately on another channel).
  - conf_hold=0: lock lasts exactly while the locked channel stays >= threshold.
- Any mode other than 10 forces the FSM to FREE and cnt to 0 on the next clk, regardless of valid.
- Reset mid-lock: immediate FREE; in-flight stage-1 sample is discarded (sel_valid=0).
- Between valid samples, lock state and cnt are frozen. Invalid cycles never count toward hold.

Decomposition:
- Shared package qmca_pkg:
  - mode encodings MODE_FIXED / MODE_AUTO / MODE_LOCK;
  - FSM state enum (FREE, LOCKED).
- Sub-module qmca_argmax:
  - parametrised (NCH, ADC_WIDTH), purely combinational;
  - lowest-index tie-break;
  - outputs index and value.
- Core contains the pipeline registers, mode mux and lock FSM.

Test Plan (NCH=4, ADC_WIDTH=14, HOLD_W=8):
- Reset/latency: assert rst mid-stream → all outputs 0 immediately. Then fixed ch2, one valid sample {10,20,30,40} → sel_valid exactly 2 clk later, channel 2, value 30, sel_locked=0.
- Fixed out-of-range: NCH=3 build, conf_channel=3 → channel 0, conf_error=1. Set conf_channel=1 → conf_error=0, adc1 output.
- Auto ties: {500,500,100,500} → channel 0. {1,2,3,16383} → channel 3, value 16383 (full width, no overflow).
- Lock/hold: mode 10, thr=1000, hold=2. Sample stream:
  - ch1=1200 (others 0) → lock ch1;
  - next two samples ch1=0, ch3=5000 → still ch1, locked;
  - third such sample → release and re-lock ch3, value 5000, sel_locked=1.
- Lock with gaps: same config, lock, then 5 idle cycles (adc_valid=0) → cnt unchanged. Hold still expires only after 2 further valid samples.
- Mode exit: while LOCKED switch to mode 01 → next valid sample is argmax with sel_locked=0. Switch back to 10 → FSM starts in FREE.
